// File: rtl/alu_issue_seq_pkg.sv
// Shared widths, MiniMIPS opcode values, ALU funct codes and FSM encodings
// for the alu_issue_seq execute sequencer.
package alu_issue_seq_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int ALU_FUNCT_WIDTH = 6;
  localparam int REG_ADDR_WIDTH  = 5;
  localparam int DATA_MSB        = DATA_WIDTH - 1;
  localparam int FUNCT_MSB       = ALU_FUNCT_WIDTH - 1;
  localparam int REG_ADDR_MSB    = REG_ADDR_WIDTH - 1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_MULI  = 6'h1d;

  localparam logic [FUNCT_MSB:0] ALU_SLL = 6'h01;
  localparam logic [FUNCT_MSB:0] ALU_SRL = 6'h02;
  localparam logic [FUNCT_MSB:0] ALU_ADD = 6'h20;
  localparam logic [FUNCT_MSB:0] ALU_SUB = 6'h22;
  localparam logic [FUNCT_MSB:0] ALU_AND = 6'h24;
  localparam logic [FUNCT_MSB:0] ALU_OR  = 6'h25;
  localparam logic [FUNCT_MSB:0] ALU_NOR = 6'h27;
  localparam logic [FUNCT_MSB:0] ALU_SLT = 6'h2a;
  localparam logic [FUNCT_MSB:0] ALU_MUL = 6'h2c;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_issue_seq_if.sv
// Request / ALU / response bundle of the sequencer. The master modport is the
// sequencer itself (initiator toward the ALU); slave is the surrounding pipeline.
interface alu_issue_seq_if;
  import alu_issue_seq_pkg::*;

  logic                      req_valid;
  logic                      req_ready;
  logic [DATA_MSB:0]         req_instr;
  logic [DATA_MSB:0]         req_rs_data;
  logic [DATA_MSB:0]         req_rt_data;
  logic [DATA_MSB:0]         alu_op1;
  logic [DATA_MSB:0]         alu_op2;
  logic [FUNCT_MSB:0]        alu_funct;
  logic [DATA_MSB:0]         alu_result;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_MSB:0]         rsp_result;
  logic [REG_ADDR_MSB:0]     rsp_waddr;
  logic                      rsp_wen;
  logic                      rsp_err;
  logic                      rsp_ovf;

  modport master (
    input  req_valid, req_instr, req_rs_data, req_rt_data,
    output req_ready,
    output alu_op1, alu_op2, alu_funct,
    input  alu_result,
    output rsp_valid, rsp_result, rsp_waddr, rsp_wen, rsp_err, rsp_ovf,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_instr, req_rs_data, req_rt_data,
    input  req_ready,
    input  alu_op1, alu_op2, alu_funct,
    output alu_result,
    input  rsp_valid, rsp_result, rsp_waddr, rsp_wen, rsp_err, rsp_ovf,
    output rsp_ready
  );

endinterface

// File: rtl/alu_issue_decode.sv
// Combinational MiniMIPS arithmetic decode: instruction + register values to
// ALU operands, funct, write-back address and an illegal flag.
module alu_issue_decode
  import alu_issue_seq_pkg::*;
(
  input  logic [DATA_MSB:0]     instr,
  input  logic [DATA_MSB:0]     rs_data,
  input  logic [DATA_MSB:0]     rt_data,
  output logic [DATA_MSB:0]     op1,
  output logic [DATA_MSB:0]     op2,
  output logic [FUNCT_MSB:0]    funct,
  output logic [REG_ADDR_MSB:0] waddr,
  output logic                  illegal
);

  logic [5:0]              opcode;
  logic [REG_ADDR_MSB:0]   rt_field;
  logic [REG_ADDR_MSB:0]   rd_field;
  logic [4:0]              shamt;
  logic [FUNCT_MSB:0]      r_funct;
  logic [DATA_MSB:0]       imm_se;
  logic [DATA_MSB:0]       imm_ze;

  // rs field (instr[25:21]) only selects rs_data upstream, so it is not decoded here
  assign opcode   = instr[31:26];
  assign rt_field = instr[20:16];
  assign rd_field = instr[15:11];
  assign shamt    = instr[10:6];
  assign r_funct  = instr[5:0];
  assign imm_se   = {{16{instr[15]}}, instr[15:0]};
  assign imm_ze   = {16'h0000, instr[15:0]};

  always_comb begin
    op1     = rs_data;
    op2     = rt_data;
    funct   = ALU_ADD;
    waddr   = rt_field;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        waddr = rd_field;
        case (r_funct)
          ALU_ADD, ALU_SUB, ALU_MUL, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT: begin
            funct = r_funct;
          end
          ALU_SLL, ALU_SRL: begin
            op1   = rt_data;
            op2   = {27'd0, shamt};
            funct = r_funct;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin funct = ALU_ADD; op2 = imm_se; end
      OP_MULI: begin funct = ALU_MUL; op2 = imm_se; end
      OP_SLTI: begin funct = ALU_SLT; op2 = imm_se; end
      OP_ANDI: begin funct = ALU_AND; op2 = imm_ze; end
      OP_ORI:  begin funct = ALU_OR;  op2 = imm_ze; end
      // lui is executed as imm << 16 on the shifter
      OP_LUI: begin
        op1   = imm_ze;
        op2   = 32'd16;
        funct = ALU_SLL;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_seq.sv
// Three-state (IDLE/EXEC/RESP) execute sequencer driving an external ALU.
// Optional signed-overflow flag for add/sub/addi under ALU_ISSUE_SEQ_OVF_EN.
module alu_issue_seq
  import alu_issue_seq_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  alu_issue_seq_if.master bus
);

  logic [1:0]              state_reg, state_next;
  logic [DATA_MSB:0]       op1_reg, op2_reg, result_reg;
  logic [FUNCT_MSB:0]      funct_reg;
  logic [REG_ADDR_MSB:0]   waddr_reg;
  logic                    wen_reg, err_reg;
  logic                    req_ready;
  logic                    req_fire;

  logic [DATA_MSB:0]       dec_op1, dec_op2;
  logic [FUNCT_MSB:0]      dec_funct;
  logic [REG_ADDR_MSB:0]   dec_waddr;
  logic                    dec_illegal;

  alu_issue_decode u_decode (
    .instr   (bus.req_instr),
    .rs_data (bus.req_rs_data),
    .rt_data (bus.req_rt_data),
    .op1     (dec_op1),
    .op2     (dec_op2),
    .funct   (dec_funct),
    .waddr   (dec_waddr),
    .illegal (dec_illegal)
  );

  // ready is forced low for the whole time reset is held, not just after the edge
  assign req_ready = RST && (state_reg == ST_IDLE);
  assign req_fire  = bus.req_valid && req_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req_fire) state_next = dec_illegal ? ST_RESP : ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef ALU_ISSUE_SEQ_OVF_EN
  logic              ovf_reg;
  logic [DATA_MSB:0] op2_eff;
  logic              ovf_calc;

  assign op2_eff  = (funct_reg == ALU_SUB) ? ~op2_reg : op2_reg;
  assign ovf_calc = ((funct_reg == ALU_ADD) || (funct_reg == ALU_SUB)) &&
                    (op1_reg[DATA_MSB] == op2_eff[DATA_MSB]) &&
                    (bus.alu_result[DATA_MSB] != op1_reg[DATA_MSB]);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == ST_EXEC) begin
      ovf_reg <= ovf_calc;
    end else if (req_fire) begin
      ovf_reg <= 1'b0;
    end
  end

  assign bus.rsp_ovf = ovf_reg;
`else
  assign bus.rsp_ovf = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg  <= ST_IDLE;
      op1_reg    <= '0;
      op2_reg    <= '0;
      funct_reg  <= ALU_ADD;
      result_reg <= '0;
      waddr_reg  <= '0;
      wen_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (req_fire) begin
        waddr_reg <= dec_waddr;
        if (dec_illegal) begin
          err_reg    <= 1'b1;
          result_reg <= '0;
          wen_reg    <= 1'b0;
        end else begin
          err_reg   <= 1'b0;
          op1_reg   <= dec_op1;
          op2_reg   <= dec_op2;
          funct_reg <= dec_funct;
        end
      end
      // writes to $0 are computed but never committed
      if (state_reg == ST_EXEC) begin
        result_reg <= bus.alu_result;
        wen_reg    <= (waddr_reg != '0);
      end
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.alu_op1    = op1_reg;
  assign bus.alu_op2    = op2_reg;
  assign bus.alu_funct  = funct_reg;
  assign bus.rsp_valid  = (state_reg == ST_RESP);
  assign bus.rsp_result = result_reg;
  assign bus.rsp_waddr  = waddr_reg;
  assign bus.rsp_wen    = wen_reg;
  assign bus.rsp_err    = err_reg;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed testbench for alu_issue_seq with a behavioural ALU beside the DUT.
// Overflow expectations follow ALU_ISSUE_SEQ_OVF_EN.
module tb_alu_issue_seq;

  logic CLK;
  logic RST;
  int   pass_cnt;
  int   total_cnt;

  alu_issue_seq_if ifc ();

  alu_issue_seq dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // reference ALU, independent of the DUT
  always_comb begin
    ifc.alu_result = 'x;
    case (ifc.alu_funct)
      6'h20: ifc.alu_result = ifc.alu_op1 + ifc.alu_op2;
      6'h22: ifc.alu_result = ifc.alu_op1 - ifc.alu_op2;
      6'h2c: ifc.alu_result = ifc.alu_op1 * ifc.alu_op2;
      6'h24: ifc.alu_result = ifc.alu_op1 & ifc.alu_op2;
      6'h25: ifc.alu_result = ifc.alu_op1 | ifc.alu_op2;
      6'h27: ifc.alu_result = ~(ifc.alu_op1 | ifc.alu_op2);
      6'h2a: ifc.alu_result = {31'd0, $signed(ifc.alu_op1) < $signed(ifc.alu_op2)};
      6'h01: ifc.alu_result = ifc.alu_op1 << ifc.alu_op2[4:0];
      6'h02: ifc.alu_result = ifc.alu_op1 >> ifc.alu_op2[4:0];
      default: ifc.alu_result = 'x;
    endcase
  end

  // Present a request and wait (bounded) for the accepting edge; returns #1 after it.
  task automatic issue(input logic [31:0] instr, input logic [31:0] rs,
                       input logic [31:0] rt, output bit ok);
    ifc.req_instr   = instr;
    ifc.req_rs_data = rs;
    ifc.req_rt_data = rt;
    ifc.req_valid   = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (ifc.req_ready === 1'b1) ok = 1'b1;
      @(posedge CLK); #1;
    end
    ifc.req_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    ifc.rsp_ready = 1'b1;
    @(posedge CLK); #1;
    ifc.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #12;
    total_cnt++; if (ifc.req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b expected 0", ifc.req_ready); else pass_cnt++;
    total_cnt++; if (ifc.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", ifc.rsp_valid); else pass_cnt++;
    total_cnt++; if (ifc.alu_funct !== 6'h20) $display("FAIL reset_alu_funct: got %h expected 20", ifc.alu_funct); else pass_cnt++;
    total_cnt++; if ({ifc.alu_op1, ifc.alu_op2} !== 64'd0) $display("FAIL reset_alu_ops: got %h/%h expected 0/0", ifc.alu_op1, ifc.alu_op2); else pass_cnt++;
    total_cnt++; if ({ifc.rsp_result, ifc.rsp_waddr, ifc.rsp_wen, ifc.rsp_err, ifc.rsp_ovf} !== 40'd0)
      $display("FAIL reset_rsp_fields: got %h %h %b %b %b expected all 0", ifc.rsp_result, ifc.rsp_waddr, ifc.rsp_wen, ifc.rsp_err, ifc.rsp_ovf); else pass_cnt++;
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    total_cnt++; if (ifc.req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", ifc.req_ready); else pass_cnt++;
  endtask

  task automatic test_add();
    bit ok;
    issue(32'h00221820, 32'd5, 32'd7, ok);
    total_cnt++; if (!ok) $display("FAIL add_accept: got timeout expected accept"); else pass_cnt++;
    // one cycle after accept: EXEC, ALU inputs loaded, no response yet
    total_cnt++; if (ifc.alu_funct !== 6'h20) $display("FAIL add_exec_funct: got %h expected 20", ifc.alu_funct); else pass_cnt++;
    total_cnt++; if ({ifc.alu_op1, ifc.alu_op2} !== {32'd5, 32'd7}) $display("FAIL add_exec_ops: got %h/%h expected 5/7", ifc.alu_op1, ifc.alu_op2); else pass_cnt++;
    total_cnt++; if (ifc.rsp_valid !== 1'b0) $display("FAIL add_exec_rsp_valid: got %b expected 0", ifc.rsp_valid); else pass_cnt++;
    total_cnt++; if (ifc.req_ready !== 1'b0) $display("FAIL add_exec_req_ready: got %b expected 0", ifc.req_ready); else pass_cnt++;
    @(posedge CLK); #1;
    total_cnt++; if (ifc.rsp_valid !== 1'b1) $display("FAIL add_rsp_valid: got %b expected 1", ifc.rsp_valid); else pass_cnt++;
    total_cnt++; if (ifc.rsp_result !== 32'd12) $display("FAIL add_result: got %h expected 0000000c", ifc.rsp_result); else pass_cnt++;
    total_cnt++; if ({ifc.rsp_waddr, ifc.rsp_wen, ifc.rsp_err, ifc.rsp_ovf} !== {5'd3, 1'b1, 1'b0, 1'b0})
      $display("FAIL add_rsp_flags: got waddr=%0d wen=%b err=%b ovf=%b expected 3 1 0 0", ifc.rsp_waddr, ifc.rsp_wen, ifc.rsp_err, ifc.rsp_ovf); else pass_cnt++;
    finish_rsp();
    total_cnt++; if ({ifc.rsp_valid, ifc.req_ready} !== 2'b01) $display("FAIL add_return_idle: got valid=%b ready=%b expected 0 1", ifc.rsp_valid, ifc.req_ready); else pass_cnt++;
  endtask

  task automatic test_addi();
    bit ok;
    issue(32'h2022FFFF, 32'd5, 32'hCAFE0000, ok);
    total_cnt++; if (!ok) $display("FAIL addi_accept: got timeout expected accept"); else pass_cnt++;
    total_cnt++; if (ifc.alu_op2 !== 32'hFFFFFFFF) $display("FAIL addi_op2: got %h expected ffffffff", ifc.alu_op2); else pass_cnt++;
    @(posedge CLK); #1;
    total_cnt++; if ({ifc.rsp_result, ifc.rsp_waddr} !== {32'd4, 5'd2}) $display("FAIL addi_rsp: got %h waddr=%0d expected 00000004 waddr=2", ifc.rsp_result, ifc.rsp_waddr); else pass_cnt++;
    finish_rsp();
  endtask

  task automatic test_lui_sll();
    bit ok;
    issue(32'h3C041234, 32'hDEADBEEF, 32'h0, ok);
    total_cnt++; if (!ok) $display("FAIL lui_accept: got timeout expected accept"); else pass_cnt++;
    total_cnt++; if ({ifc.alu_op1, ifc.alu_op2, ifc.alu_funct} !== {32'h1234, 32'd16, 6'h01})
      $display("FAIL lui_exec: got %h/%h/%h expected 00001234/00000010/01", ifc.alu_op1, ifc.alu_op2, ifc.alu_funct); else pass_cnt++;
    @(posedge CLK); #1;
    total_cnt++; if ({ifc.rsp_result, ifc.rsp_waddr} !== {32'h12340000, 5'd4}) $display("FAIL lui_rsp: got %h waddr=%0d expected 12340000 waddr=4", ifc.rsp_result, ifc.rsp_waddr); else pass_cnt++;
    finish_rsp();
    issue(32'h00021901, 32'h55, 32'd3, ok);
    total_cnt++; if (!ok) $display("FAIL sll_accept: got timeout expected accept"); else pass_cnt++;
    total_cnt++; if ({ifc.alu_op1, ifc.alu_op2} !== {32'd3, 32'd4}) $display("FAIL sll_exec_ops: got %h/%h expected 3/4", ifc.alu_op1, ifc.alu_op2); else pass_cnt++;
    @(posedge CLK); #1;
    total_cnt++; if ({ifc.rsp_result, ifc.rsp_waddr} !== {32'h30, 5'd3}) $display("FAIL sll_rsp: got %h waddr=%0d expected 00000030 waddr=3", ifc.rsp_result, ifc.rsp_waddr); else pass_cnt++;
    finish_rsp();
  endtask

  task automatic test_op_table();
    logic [31:0] t_instr [6] = '{32'h00221822, 32'h00221827, 32'h00021882, 32'h7422FFFD, 32'h2822FFFF, 32'h3022FFFF};
    logic [31:0] t_rs    [6] = '{32'd5, 32'hF0F0F0F0, 32'h0, 32'd7, 32'hFFFFFFFE, 32'h12345678};
    logic [31:0] t_rt    [6] = '{32'd7, 32'h0F0F0000, 32'h80, 32'h0, 32'h0, 32'h0};
    logic [31:0] t_op2   [6] = '{32'd7, 32'h0F0F0000, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h0000FFFF};
    logic [5:0]  t_fn    [6] = '{6'h22, 6'h27, 6'h02, 6'h2c, 6'h2a, 6'h24};
    logic [31:0] t_res   [6] = '{32'hFFFFFFFE, 32'h00000F0F, 32'h20, 32'hFFFFFFEB, 32'd1, 32'h5678};
    logic [4:0]  t_wa    [6] = '{5'd3, 5'd3, 5'd3, 5'd2, 5'd2, 5'd2};
    bit ok;
    for (int i = 0; i < 6; i++) begin
      issue(t_instr[i], t_rs[i], t_rt[i], ok);
      total_cnt++; if (!ok || ifc.alu_op2 !== t_op2[i] || ifc.alu_funct !== t_fn[i])
        $display("FAIL table%0d_exec: got op2=%h funct=%h accepted=%b expected op2=%h funct=%h", i, ifc.alu_op2, ifc.alu_funct, ok, t_op2[i], t_fn[i]); else pass_cnt++;
      @(posedge CLK); #1;
      total_cnt++; if ({ifc.rsp_valid, ifc.rsp_result, ifc.rsp_waddr, ifc.rsp_wen} !== {1'b1, t_res[i], t_wa[i], 1'b1})
        $display("FAIL table%0d_rsp: got valid=%b result=%h waddr=%0d wen=%b expected 1 %h %0d 1", i, ifc.rsp_valid, ifc.rsp_result, ifc.rsp_waddr, ifc.rsp_wen, t_res[i], t_wa[i]); else pass_cnt++;
      finish_rsp();
    end
  endtask

  task automatic test_illegal();
    bit ok;
    issue(32'hFC000000, 32'd1, 32'd2, ok);
    total_cnt++; if (!ok) $display("FAIL illegal_accept: got timeout expected accept"); else pass_cnt++;
    // illegal skips EXEC: response one cycle after accept
    total_cnt++; if ({ifc.rsp_valid, ifc.rsp_err, ifc.rsp_wen, ifc.rsp_result} !== {1'b1, 1'b1, 1'b0, 32'd0})
      $display("FAIL illegal_opcode_rsp: got valid=%b err=%b wen=%b result=%h expected 1 1 0 0", ifc.rsp_valid, ifc.rsp_err, ifc.rsp_wen, ifc.rsp_result); else pass_cnt++;
    finish_rsp();
    issue(32'h00221803, 32'd1, 32'd2, ok);
    total_cnt++; if ({ok, ifc.rsp_valid, ifc.rsp_err, ifc.rsp_wen} !== 4'b1110)
      $display("FAIL illegal_funct_rsp: got accepted=%b valid=%b err=%b wen=%b expected 1 1 1 0", ok, ifc.rsp_valid, ifc.rsp_err, ifc.rsp_wen); else pass_cnt++;
    finish_rsp();
    issue(32'h00220020, 32'd5, 32'd7, ok);
    @(posedge CLK); #1;
    total_cnt++; if ({ok, ifc.rsp_valid, ifc.rsp_err, ifc.rsp_wen, ifc.rsp_waddr, ifc.rsp_result} !== {4'b1100, 5'd0, 32'd12})
      $display("FAIL zero_dest_rsp: got accepted=%b valid=%b err=%b wen=%b waddr=%0d result=%h expected 1 1 0 0 0 0000000c",
               ok, ifc.rsp_valid, ifc.rsp_err, ifc.rsp_wen, ifc.rsp_waddr, ifc.rsp_result); else pass_cnt++;
    finish_rsp();
  endtask

  task automatic test_back_pressure();
    bit ok;
    issue(32'h00221820, 32'd5, 32'd7, ok);
    @(posedge CLK); #1;
    // offer the next request while the response is stalled
    ifc.req_instr   = 32'h34430F0F;
    ifc.req_rs_data = 32'hF0F00000;
    ifc.req_rt_data = 32'h0;
    ifc.req_valid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if ({ok, ifc.rsp_valid, ifc.req_ready, ifc.rsp_result, ifc.rsp_waddr, ifc.rsp_wen} !== {3'b110, 32'd12, 5'd3, 1'b1})
        $display("FAIL stall%0d_hold: got accepted=%b valid=%b req_ready=%b result=%h waddr=%0d wen=%b expected 1 1 0 0000000c 3 1",
                 i, ok, ifc.rsp_valid, ifc.req_ready, ifc.rsp_result, ifc.rsp_waddr, ifc.rsp_wen); else pass_cnt++;
      @(posedge CLK); #1;
    end
    ifc.rsp_ready = 1'b1;
    @(posedge CLK); #1;
    ifc.rsp_ready = 1'b0;
    total_cnt++; if ({ifc.rsp_valid, ifc.req_ready} !== 2'b01) $display("FAIL stall_release: got valid=%b req_ready=%b expected 0 1", ifc.rsp_valid, ifc.req_ready); else pass_cnt++;
    @(posedge CLK); #1;
    ifc.req_valid = 1'b0;
    total_cnt++; if ({ifc.alu_funct, ifc.alu_op1, ifc.alu_op2} !== {6'h25, 32'hF0F00000, 32'h00000F0F})
      $display("FAIL queued_ori_exec: got %h/%h/%h expected 25/f0f00000/00000f0f", ifc.alu_funct, ifc.alu_op1, ifc.alu_op2); else pass_cnt++;
    @(posedge CLK); #1;
    total_cnt++; if ({ifc.rsp_valid, ifc.rsp_result, ifc.rsp_waddr} !== {1'b1, 32'hF0F00F0F, 5'd3})
      $display("FAIL queued_ori_rsp: got valid=%b result=%h waddr=%0d expected 1 f0f00f0f 3", ifc.rsp_valid, ifc.rsp_result, ifc.rsp_waddr); else pass_cnt++;
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    issue(32'h00221820, 32'd9, 32'd9, ok);
    #2; RST = 1'b0;
    #1;
    total_cnt++; if ({ok, ifc.req_ready, ifc.rsp_valid, ifc.alu_funct, ifc.alu_op1, ifc.alu_op2} !== {3'b100, 6'h20, 64'd0})
      $display("FAIL midreset_outputs: got accepted=%b ready=%b valid=%b funct=%h op1=%h op2=%h expected 1 0 0 20 0 0",
               ok, ifc.req_ready, ifc.rsp_valid, ifc.alu_funct, ifc.alu_op1, ifc.alu_op2); else pass_cnt++;
    @(negedge CLK); RST = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      if (ifc.rsp_valid !== 1'b0) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0 || ifc.req_ready !== 1'b1) $display("FAIL midreset_no_rsp: got spurious=%b ready=%b expected 0 1", seen, ifc.req_ready); else pass_cnt++;
  endtask

  task automatic test_overflow();
    bit ok;
    issue(32'h00221820, 32'h7FFFFFFF, 32'd1, ok);
    @(posedge CLK); #1;
`ifdef ALU_ISSUE_SEQ_OVF_EN
    total_cnt++; if ({ok, ifc.rsp_result, ifc.rsp_ovf, ifc.rsp_wen} !== {1'b1, 32'h80000000, 1'b1, 1'b1})
      $display("FAIL add_ovf: got accepted=%b result=%h ovf=%b wen=%b expected 1 80000000 1 1", ok, ifc.rsp_result, ifc.rsp_ovf, ifc.rsp_wen); else pass_cnt++;
`else
    total_cnt++; if ({ok, ifc.rsp_result, ifc.rsp_ovf, ifc.rsp_wen} !== {1'b1, 32'h80000000, 1'b0, 1'b1})
      $display("FAIL add_ovf_off: got accepted=%b result=%h ovf=%b wen=%b expected 1 80000000 0 1", ok, ifc.rsp_result, ifc.rsp_ovf, ifc.rsp_wen); else pass_cnt++;
`endif
    finish_rsp();
  endtask

  initial begin
    pass_cnt        = 0;
    total_cnt       = 0;
    ifc.req_valid   = 1'b0;
    ifc.req_instr   = '0;
    ifc.req_rs_data = '0;
    ifc.req_rt_data = '0;
    ifc.rsp_ready   = 1'b0;
    test_reset();
    test_add();
    test_addi();
    test_lui_sll();
    test_op_table();
    test_illegal();
    test_back_pressure();
    test_reset_mid();
    test_overflow();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
